// File: rtl/seq_pkg.sv
// Shared types and helpers for the fetch sequencer: FSM state encoding and
// sign extension of PC-relative branch offsets.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int MAX_PC_W = 32;

    // Replicates bit w-1 of a w-bit offset into all higher bits.
    function automatic logic [MAX_PC_W-1:0] sext_offset(
        input logic [MAX_PC_W-1:0] off,
        input int                  w
    );
        logic [MAX_PC_W-1:0] r;
        r = off;
        for (int i = 0; i < MAX_PC_W; i++) begin
            if (i >= w) r[i] = off[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO of DEPTH entries; clear has priority over push and pop,
// push is ignored when full and pop is ignored when empty.
module seq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             do_push;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr_idx  = IDX_W'(cnt_q);
    assign rd_idx  = IDX_W'(cnt_q - CNT_W'(1));
    assign top_o   = mem_q[rd_idx];
    assign do_push = push_i && !full_o && !clear_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clear_i)                  cnt_d = '0;
        else if (do_push)             cnt_d = cnt_q + CNT_W'(1);
        else if (pop_i && !empty_o)   cnt_d = cnt_q - CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // NOTE: the storage array has no reset; the occupancy count defines which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC generation with branches, calls, returns,
// halt and a RUN-cycle counter. Optional watchdog under SEQ_WATCHDOG_EN.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int STACK_D  = 4,
    parameter int CYC_W    = 16,
    parameter int WDOG_CYC = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [PC_W-1:0]  Target,
    input  logic             Call,
    input  logic             Ret,
    output logic [PC_W-1:0]  PgmCtr,
    output logic             Running,
    output logic             Ack,
    output logic             StackErr,
    output logic             Timeout,
    output logic [CYC_W-1:0] CycleCt
);

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             err_q, err_d;

    logic             push, pop, clear;
    logic             stk_full, stk_empty;
    logic [PC_W-1:0]  stk_top;
    logic [PC_W-1:0]  pc_inc, off_pc, dest;

    assign pc_inc = pc_q + PC_W'(1);
    assign off_pc = PC_W'(sext_offset(MAX_PC_W'(Target), PC_W));
    assign dest   = BranchAbs ? Target : pc_q + off_pc;

`ifdef SEQ_WATCHDOG_EN
    logic to_q, to_d;
    logic wdog_hit;
    // Fires on the RUN cycle whose count increment reaches the limit.
    assign wdog_hit = (32'(cyc_q) + 32'd1) >= 32'(WDOG_CYC);
    assign Timeout  = to_q;
`else
    assign Timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        to_d    = to_q;
`endif
        if (Start) begin
            state_d = RUN;
            pc_d    = '0;
            cyc_d   = '0;
            err_d   = 1'b0;
            clear   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
            to_d    = 1'b0;
`endif
        end else if (state_q == RUN) begin
            // The counter tracks wall-clock time in RUN, stalled or not.
            if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
            if (!Stall) begin
                if (Halt) begin
                    state_d = DONE;
                end else if (Ret) begin
                    if (stk_empty) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end else if (Call) begin
                    if (stk_full) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        push = 1'b1;
                        pc_d = dest;
                    end
                end else if (BranchEn) begin
                    pc_d = dest;
                end else begin
                    pc_d = pc_inc;
                end
            end
`ifdef SEQ_WATCHDOG_EN
            if (wdog_hit) begin
                state_d = DONE;
                to_d    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) to_q <= 1'b0;
        else       to_q <= to_d;
    end
`endif

    seq_stack #(
        .DEPTH (STACK_D),
        .WIDTH (PC_W)
    ) u_stack (
        .clk     (Clk),
        .rst     (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign PgmCtr   = pc_q;
    assign Running  = (state_q == RUN);
    assign Ack      = (state_q == DONE);
    assign StackErr = err_q;
    assign CycleCt  = cyc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios plus random control
// traffic, compared against a queue-based behavioural model.
module tb_fetch_sequencer;

    localparam int PC_W     = 10;
    localparam int STACK_D  = 4;
    localparam int CYC_W    = 6;
    localparam int WDOG_CYC = 8;
    localparam int M        = 1 << PC_W;
    localparam int CYC_MAX  = (1 << CYC_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0, Stall = 1'b0, Halt = 1'b0;
    logic             BranchEn = 1'b0, BranchAbs = 1'b0, Call = 1'b0, Ret = 1'b0;
    logic [PC_W-1:0]  Target = '0;
    logic [PC_W-1:0]  PgmCtr;
    logic             Running, Ack, StackErr, Timeout;
    logic [CYC_W-1:0] CycleCt;

    fetch_sequencer #(
        .PC_W     (PC_W),
        .STACK_D  (STACK_D),
        .CYC_W    (CYC_W),
        .WDOG_CYC (WDOG_CYC)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Stall     (Stall),
        .Halt      (Halt),
        .BranchEn  (BranchEn),
        .BranchAbs (BranchAbs),
        .Target    (Target),
        .Call      (Call),
        .Ret       (Ret),
        .PgmCtr    (PgmCtr),
        .Running   (Running),
        .Ack       (Ack),
        .StackErr  (StackErr),
        .Timeout   (Timeout),
        .CycleCt   (CycleCt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int pc;
        bit run;
        bit ack;
        bit err;
        bit to;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    int   m_pc, m_cyc;
    bit   m_run, m_done, m_err, m_to;
    int   m_stack[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_cyc = 0; m_run = 0; m_done = 0; m_err = 0; m_to = 0;
        m_stack.delete();
    endfunction

    function automatic void model_step(input bit st, sl, h, be, ba, c, r, input int tg);
        int off, dest;
        bit fin, wd;
        off  = (tg >= M / 2) ? tg - M : tg;
        dest = ba ? tg : (((m_pc + off) % M) + M) % M;
        if (st) begin
            m_pc = 0; m_cyc = 0; m_err = 0; m_to = 0;
            m_run = 1; m_done = 0;
            m_stack.delete();
        end else if (m_run) begin
            fin = 0;
            wd  = 0;
`ifdef SEQ_WATCHDOG_EN
            wd = (m_cyc + 1 >= WDOG_CYC);
`endif
            if (m_cyc < CYC_MAX) m_cyc++;
            if (!sl) begin
                if (h) fin = 1;
                else if (r) begin
                    if (m_stack.size() == 0) begin m_err = 1; fin = 1; end
                    else m_pc = m_stack.pop_back();
                end else if (c) begin
                    if (m_stack.size() == STACK_D) begin m_err = 1; fin = 1; end
                    else begin m_stack.push_back((m_pc + 1) % M); m_pc = dest; end
                end else if (be) m_pc = dest;
                else m_pc = (m_pc + 1) % M;
            end
            if (wd) begin fin = 1; m_to = 1; end
            if (fin) begin m_run = 0; m_done = 1; end
        end
    endfunction

    // One clock of stimulus: drive at negedge, record the expected post-edge
    // outputs, return shortly after the edge so callers may probe directly.
    task automatic step(input bit st, sl, h, be, ba, c, r, input int tg);
        exp_t e;
        @(negedge Clk);
        Start = st; Stall = sl; Halt = h; BranchEn = be; BranchAbs = ba;
        Call = c; Ret = r; Target = PC_W'(tg);
        model_step(st, sl, h, be, ba, c, r, tg);
        e.pc = m_pc; e.run = m_run; e.ack = m_done; e.err = m_err; e.to = m_to; e.cyc = m_cyc;
        sbq.push_back(e);
        @(posedge Clk);
        #2;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, PgmCtr, 0);
        check({tag, "_run"}, Running, 0);
        check({tag, "_ack"}, Ack, 0);
        check({tag, "_err"}, StackErr, 0);
        check({tag, "_to"}, Timeout, 0);
        check({tag, "_cyc"}, CycleCt, 0);
    endtask

    // Asserts reset at the current time, probes asynchronously, then releases.
    task automatic apply_reset(input string tag);
        Reset = 1'b1;
        Start = 0; Stall = 0; Halt = 0; BranchEn = 0; BranchAbs = 0;
        Call = 0; Ret = 0; Target = '0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: every output cycle with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_pc", PgmCtr, e.pc);
                check("sb_running", Running, e.run);
                check("sb_ack", Ack, e.ack);
                check("sb_stackerr", StackErr, e.err);
                check("sb_timeout", Timeout, e.to);
                check("sb_cyclect", CycleCt, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit st, sl, h, be, ba, c, r;
        int tg;

        #3;
        apply_reset("reset");
        idle_step();
        check("idle_hold_run", Running, 0);

        // Straight-line fetch.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) idle_step();
        check("seq_pc", PgmCtr, 5);
        check("seq_cyc", CycleCt, 5);
        check("seq_run", Running, 1);

        // Relative branch backwards and PC wrap.
        step(0, 0, 0, 1, 1, 0, 0, 10);
        step(0, 0, 0, 1, 0, 0, 0, M - 3);
        check("rel_branch_pc", PgmCtr, 7);
        step(0, 0, 0, 1, 1, 0, 0, M - 1);
        idle_step();
        check("wrap_pc", PgmCtr, 0);
        check("wrap_err", StackErr, 0);

        // Call / return, then overflow the stack.
        step(0, 0, 0, 1, 1, 0, 0, 20);
        step(0, 0, 0, 0, 1, 1, 0, 100);
        check("call_pc", PgmCtr, 100);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("ret_pc", PgmCtr, 21);
        repeat (5) step(0, 0, 0, 0, 1, 1, 0, 100);
        check("ovf_err", StackErr, 1);
        check("ovf_ack", Ack, 1);
        check("ovf_pc", PgmCtr, 100);

        // Restart from DONE clears the sticky flags.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("restart_pc", PgmCtr, 0);
        check("restart_ack", Ack, 0);
        check("restart_err", StackErr, 0);

        // Halt held off by stall.
        repeat (6) idle_step();
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        check("stall_pc", PgmCtr, 6);
        check("stall_ack", Ack, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("halt_ack", Ack, 1);
        check("halt_pc", PgmCtr, 6);
        idle_step();
        check("done_ignore_pc", PgmCtr, 6);

        // Return with an empty stack.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("underflow_err", StackErr, 1);
        check("underflow_ack", Ack, 1);

        // Counter saturation across a long stall.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (CYC_MAX + 6) step(0, 1, 0, 0, 0, 0, 0, 0);
`ifndef SEQ_WATCHDOG_EN
        check("cyc_saturate", CycleCt, CYC_MAX);
`endif

        // Reset in the middle of a call.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0, 50);
        apply_reset("midcall_reset");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            st = m_run ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 30);
            sl = ($urandom_range(0, 99) < 15);
            h  = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 99) < 20);
            c  = ($urandom_range(0, 99) < 20);
            be = ($urandom_range(0, 99) < 25);
            ba = $urandom_range(0, 1);
            tg = $urandom_range(0, M - 1);
            step(st, sl, h, be, ba, c, r, tg);
        end

        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
